// File: rtl/lane_stripe_scheduler.sv
// lane_stripe_scheduler: stripes DATA_LANES-byte words across the negotiated
// link width, serializing a word into several beats on narrow links, and
// inserts a periodic SKP ordered set between words on all active lanes.
module lane_stripe_scheduler #(
   parameter int  DATA_LANES   = 4,
   parameter int  SKP_INTERVAL = 1180,
   localparam int WW           = $clog2(DATA_LANES) + 1
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [WW-1:0]           i_cfg_width,
   input  logic [8*DATA_LANES-1:0] i_in_data,
   input  logic [DATA_LANES-1:0]   i_in_k,
   input  logic                    i_in_valid,
   output logic                    o_in_ready,
   output logic [8*DATA_LANES-1:0] o_lane_data,
   output logic [DATA_LANES-1:0]   o_lane_k,
   output logic [DATA_LANES-1:0]   o_lane_en,
   output logic                    o_skp_active,
   output logic [WW-1:0]           o_width_active
);
   localparam int LW = $clog2(DATA_LANES);
   localparam int BW = (LW > 0) ? LW : 1;
   localparam int CW = $clog2(SKP_INTERVAL);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_SKP  = 2'd2;

   localparam logic [7:0] SYM_COM = 8'hBC;
   localparam logic [7:0] SYM_SKP = 8'h1C;

   logic [1:0]              r_state;
   logic [BW-1:0]           r_beat;
   logic [1:0]              r_sym;
   logic [8*DATA_LANES-1:0] r_word;
   logic [DATA_LANES-1:0]   r_kw;
   logic [WW-1:0]           r_width_q;
   logic [CW-1:0]           r_skp_cnt;
   logic                    r_skp_pend;

   logic [DATA_LANES-1:0][7:0] r_lane_data;
   logic [DATA_LANES-1:0]      r_lane_k;
   logic [DATA_LANES-1:0]      r_lane_en;
   logic                       r_skp_active;
   logic [WW-1:0]              r_width_active;

   logic [WW-1:0]              w_cfg_clamp;
   logic [WW-1:0]              w_eff_width;
   logic [WW-1:0]              w_owidth;
   logic                       w_last;
   logic                       w_accept;
   logic [1:0]                 w_nstate;
   logic [BW-1:0]              w_nbeat;
   logic [1:0]                 w_nsym;
   logic                       w_skp_enter;
   logic [8*DATA_LANES-1:0]    w_nword;
   logic [DATA_LANES-1:0]      w_nk;
   logic [DATA_LANES-1:0][7:0] w_lane_d;
   logic [DATA_LANES-1:0]      w_lane_k;
   logic [DATA_LANES-1:0]      w_lane_on;

   assign w_cfg_clamp = (i_cfg_width > WW'(LW)) ? WW'(LW) : i_cfg_width;
   assign w_eff_width = (r_state == S_IDLE) ? w_cfg_clamp : r_width_q;
   assign w_last      = (r_beat == BW'((DATA_LANES >> r_width_q) - 1));

   // Ready depends only on held state so the source never sees a valid->ready loop.
   assign o_in_ready  = !i_rst && !r_skp_pend &&
                        ((r_state == S_IDLE) || ((r_state == S_DATA) && w_last));
   assign w_accept    = i_in_valid && o_in_ready;

   // The word on the lanes next cycle is the freshly accepted one, else the held one.
   assign w_nword  = w_accept ? i_in_data : r_word;
   assign w_nk     = w_accept ? i_in_k    : r_kw;
   // Width shown next cycle: idle follows config live, otherwise the word's width.
   assign w_owidth = (w_nstate == S_IDLE) ? w_cfg_clamp : w_eff_width;

   // Next-state logic; SKP is only entered at a word boundary.
   always_comb begin
      w_nstate    = r_state;
      w_nbeat     = r_beat;
      w_nsym      = r_sym;
      w_skp_enter = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_nstate = S_DATA;
               w_nbeat  = '0;
            end else if (r_skp_pend) begin
               w_nstate    = S_SKP;
               w_nsym      = 2'd0;
               w_skp_enter = 1'b1;
            end
         end
         S_DATA: begin
            if (w_last) begin
               if (w_accept) begin
                  w_nbeat = '0;
               end else if (r_skp_pend) begin
                  w_nstate    = S_SKP;
                  w_nsym      = 2'd0;
                  w_skp_enter = 1'b1;
               end else begin
                  w_nstate = S_IDLE;
               end
            end else begin
               w_nbeat = r_beat + 1'b1;
            end
         end
         S_SKP: begin
            if (r_sym == 2'd3) w_nstate = S_IDLE;
            else               w_nsym   = r_sym + 2'd1;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   for (genvar gi = 0; gi < DATA_LANES; gi++) begin : g_lane
      logic [7:0] w_d;
      logic       w_k;
      logic       w_on;
      int         w_j;
      // Lane byte for next cycle: byte (beat*W + lane) of the word, SKP symbol, or idle.
      always_comb begin
         w_d  = 8'h00;
         w_k  = 1'b0;
         w_on = (gi < (1 << w_owidth));
         w_j  = (int'(w_nbeat) << w_owidth) + gi;
         if (w_on) begin
            if (w_nstate == S_SKP) begin
               w_d = (w_nsym == 2'd0) ? SYM_COM : SYM_SKP;
               w_k = 1'b1;
            end else if (w_nstate == S_DATA) begin
               w_d = 8'(w_nword >> (8 * w_j));
               w_k = 1'(w_nk >> w_j);
            end
         end
      end
      assign w_lane_d[gi]  = w_d;
      assign w_lane_k[gi]  = w_k;
      assign w_lane_on[gi] = w_on;
   end

   // Control state and held word; width latches continuously while idle.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_beat    <= '0;
         r_sym     <= 2'd0;
         r_word    <= '0;
         r_kw      <= '0;
         r_width_q <= '0;
      end else begin
         r_state <= w_nstate;
         r_beat  <= w_nbeat;
         r_sym   <= w_nsym;
         if (w_accept) begin
            r_word <= i_in_data;
            r_kw   <= i_in_k;
         end
         if (r_state == S_IDLE) r_width_q <= w_cfg_clamp;
      end
   end

   // SKP interval timer: saturates with a pending flag until SKP is entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_skp_cnt  <= '0;
         r_skp_pend <= 1'b0;
      end else if (w_skp_enter) begin
         r_skp_cnt  <= '0;
         r_skp_pend <= 1'b0;
      end else if (r_skp_cnt == CW'(SKP_INTERVAL - 1)) begin
         r_skp_pend <= 1'b1;
      end else begin
         r_skp_cnt <= r_skp_cnt + 1'b1;
      end
   end

   // Registered lane outputs; cleared asynchronously so reset blanks lanes at once.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_lane_data    <= '0;
         r_lane_k       <= '0;
         r_lane_en      <= '0;
         r_skp_active   <= 1'b0;
         r_width_active <= '0;
      end else begin
         r_lane_data    <= w_lane_d;
         r_lane_k       <= w_lane_k;
         r_lane_en      <= w_lane_on;
         r_skp_active   <= (w_nstate == S_SKP);
         r_width_active <= w_owidth;
      end
   end

   assign o_lane_data    = r_lane_data;
   assign o_lane_k       = r_lane_k;
   assign o_lane_en      = r_lane_en;
   assign o_skp_active   = r_skp_active;
   assign o_width_active = r_width_active;

endmodule

// File: tb/tb_lane_stripe_scheduler.sv
// Scoreboard bench for lane_stripe_scheduler: stimulus pushes expected beats
// on every accept, a negedge monitor pops and compares beats and checks SKPs.
module tb_lane_stripe_scheduler;
   localparam int DL  = 4;
   localparam int SKP = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic [2:0]    cfg_width;
   logic [31:0]   in_data;
   logic [3:0]    in_k;
   logic          in_valid;
   logic          in_ready;
   logic [31:0]   lane_data;
   logic [3:0]    lane_k;
   logic [3:0]    lane_en;
   logic          skp_active;
   logic [2:0]    width_active;

   lane_stripe_scheduler #(.DATA_LANES(DL), .SKP_INTERVAL(SKP)) dut (
      .i_clk(clk), .i_rst(rst), .i_cfg_width(cfg_width),
      .i_in_data(in_data), .i_in_k(in_k), .i_in_valid(in_valid),
      .o_in_ready(in_ready), .o_lane_data(lane_data), .o_lane_k(lane_k),
      .o_lane_en(lane_en), .o_skp_active(skp_active), .o_width_active(width_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] d;
      logic [3:0]  k;
      logic [3:0]  en;
      logic [2:0]  w;
      bit          last;
   } beat_t;

   beat_t sb[$];
   int    checks = 0;
   int    errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected beats of one word at link width 2**wd.
   task automatic push_word(input logic [31:0] w, input logic [3:0] k, input int wd);
      int    nl;
      int    nb;
      beat_t e;
      nl = 1 << wd;
      nb = DL >> wd;
      for (int b = 0; b < nb; b++) begin
         e.d    = '0;
         e.k    = '0;
         e.en   = 4'((1 << nl) - 1);
         e.w    = 3'(wd);
         e.last = (b == nb - 1);
         for (int i = 0; i < nl; i++) begin
            e.d[8*i +: 8] = w[8*(b*nl + i) +: 8];
            e.k[i]        = k[b*nl + i];
         end
         sb.push_back(e);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [31:0] w, input logic [3:0] k, input int wd, output int waits);
      in_data  = w;
      in_k     = k;
      in_valid = 1'b1;
      waits    = 0;
      while (!in_ready && waits < 64) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: word %h never accepted", w);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      push_word(w, k, wd);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Wait for an SKP to finish so the next test has a SKP-free window.
   task automatic sync_skp();
      int n;
      n = 0;
      while (!skp_active && n < 100) begin @(negedge clk); n++; end
      while (skp_active && n < 100)  begin @(negedge clk); n++; end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL skp_sync_timeout: no SKP seen within %0d cycles", n);
      end
   endtask

   // Monitor state
   int    cyc = 0;
   int    last_skp = 0;
   int    skp_starts = 0;
   int    skp_idx = 0;
   bit    mid_word = 0;
   bit    have_skp = 0;
   beat_t me;
   logic [31:0] exp_d;
   logic [7:0]  sym;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         mid_word = 0;
         skp_idx  = 0;
         have_skp = 0;
      end else if (skp_active) begin
         if (skp_idx == 0) begin
            chk("skp_split_word", 32'(mid_word), 32'd0);
            if (have_skp) begin
               checks++;
               if (cyc - last_skp < SKP || cyc - last_skp > SKP + DL + 1) begin
                  errors++;
                  $display("FAIL skp_spacing: got %0d cycles expected %0d..%0d", cyc - last_skp, SKP, SKP + DL + 1);
               end
            end
            have_skp = 1;
            last_skp = cyc;
            skp_starts++;
         end
         sym   = (skp_idx == 0) ? 8'hBC : 8'h1C;
         exp_d = '0;
         for (int i = 0; i < DL; i++) if (lane_en[i]) exp_d[8*i +: 8] = sym;
         chk("skp_data", lane_data, exp_d);
         chk("skp_k", 32'(lane_k), 32'(lane_en));
         chk("skp_ready", 32'(in_ready), 32'd0);
         checks++;
         if (lane_en == 4'b0 || skp_idx >= 4) begin
            errors++;
            $display("FAIL skp_shape: got en=%b sym_index=%0d expected en!=0 index<4", lane_en, skp_idx);
         end
         skp_idx++;
      end else begin
         if (skp_idx != 0) begin
            chk("skp_len", 32'(skp_idx), 32'd4);
            skp_idx = 0;
         end
         if (lane_data != 0 || lane_k != 0) begin
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL extra_beat: got data %h with nothing expected", lane_data);
            end else begin
               checks--;
               me = sb.pop_front();
               chk("beat_data", lane_data, me.d);
               chk("beat_k", 32'(lane_k), 32'(me.k));
               chk("beat_en", 32'(lane_en), 32'(me.en));
               chk("beat_width", 32'(width_active), 32'(me.w));
               mid_word = !me.last;
            end
         end else if (mid_word) begin
            checks++;
            errors++;
            $display("FAIL beat_gap: got idle lanes expected next beat of word");
            mid_word = 0;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int s0;
      rst       = 1'b1;
      cfg_width = 3'd2;
      in_data   = '0;
      in_k      = '0;
      in_valid  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_lane_data", lane_data, 32'd0);
      chk("rst_lane_en", 32'(lane_en), 32'd0);
      chk("rst_skp", 32'(skp_active), 32'd0);
      chk("rst_width", 32'(width_active), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // x4 back-to-back: one beat per word, ready never drops
      send(32'h44332211, 4'b0000, 2, w);
      chk("x4_wait0", 32'(w), 32'd0);
      send(32'h88776655, 4'b0000, 2, w);
      chk("x4_wait1", 32'(w), 32'd0);

      // x2: two beats, ready low in beat0, upper lanes off
      cfg_width = 3'd1;
      sync_skp();
      send(32'h44332211, 4'b0101, 1, w);
      chk("x2_ready_b0", 32'(in_ready), 32'd0);
      chk("x2_en", 32'(lane_en), 32'b0011);
      chk("x2_upper", 32'(lane_data[31:16]), 32'd0);
      @(negedge clk);
      chk("x2_ready_b1", 32'(in_ready), 32'd1);

      // x4 stream with cfg change mid-stream; width holds until idle
      cfg_width = 3'd2;
      sync_skp();
      send(32'h14131211, 4'b0001, 2, w);
      cfg_width = 3'd0;
      send(32'h24232221, 4'b0000, 2, w);
      send(32'h34333231, 4'b1000, 2, w);
      chk("wa_hold", 32'(width_active), 32'd2);
      @(negedge clk);
      chk("wa_idle", 32'(width_active), 32'd0);
      send(32'h04030201, 4'b0000, 0, w);

      // x1: four beats, ready only on beat 3, then reset in beat 2 of next word
      sync_skp();
      send(32'hDDCCBBAA, 4'b0000, 0, w);
      chk("x1_en", 32'(lane_en), 32'b0001);
      chk("x1_ready_b0", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("x1_ready_b1", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("x1_ready_b2", 32'(in_ready), 32'd0);
      @(negedge clk);
      chk("x1_ready_b3", 32'(in_ready), 32'd1);
      send(32'h44332211, 4'b0000, 0, w);
      chk("x1_b2b_wait", 32'(w), 32'd0);
      @(negedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      sb.delete();
      #1;
      chk("midrst_data", lane_data, 32'd0);
      chk("midrst_k", 32'(lane_k), 32'd0);
      chk("midrst_en", 32'(lane_en), 32'd0);
      chk("midrst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      chk("post_rst_width", 32'(width_active), 32'd0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_resid", lane_data, 32'd0);
      end

      // Continuous x2 traffic: SKP must appear between words, never inside one
      cfg_width = 3'd1;
      sync_skp();
      s0 = skp_starts;
      for (int i = 0; i < 12; i++) begin
         send({8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)}, 4'(i), 1, w);
      end
      repeat (8) @(negedge clk);
      checks++;
      if (skp_starts - s0 < 1) begin
         errors++;
         $display("FAIL skp_in_stream: got %0d SKPs expected at least 1", skp_starts - s0);
      end
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
